// File: rtl/qeciphy_pkg.sv
// Shared PHY-level constants for the QEC link TX/RX datapaths.
// Anything common to the encoder, decoder and their buffers lives here.
package qeciphy_pkg;

  localparam int QECIPHY_DATA_W = 64;

  function automatic bit qeciphy_is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/qeciphy_tx_buffer_if.sv
// AXI-Stream beat interface and the FIFO control interface shared by
// qeciphy_tx_buffer and its reusable pointer/level controller.
interface qeciphy_axis_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

interface qeciphy_fifo_ctrl_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic          push_req;
  logic          pop_req;
  logic          flush;
  logic          push;
  logic          can_push;
  logic          can_pop;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] level;
  logic [PW-1:0] level_nxt;

  modport master (
    output push_req, pop_req, flush,
    input  push, can_push, can_pop, wr_addr, rd_addr, level, level_nxt
  );
  modport slave (
    input  push_req, pop_req, flush,
    output push, can_push, can_pop, wr_addr, rd_addr, level, level_nxt
  );
endinterface

// File: rtl/qeciphy_sync_fifo_ctrl.sv
// Single-clock FIFO controller: wrap-bit pointers, full/empty decode and a
// registered occupancy count. Holds no data, so it serves TX and RX alike.
module qeciphy_sync_fifo_ctrl #(
  parameter int DEPTH = 16
) (
  input logic                clk_i,
  input logic                rst_n_i,
  qeciphy_fifo_ctrl_if.slave ctrl
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          active_q, active_d;
  logic          empty, full, can_push, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // active_q keeps tready low until the first edge after reset release.
  assign can_push = active_q && !full && !ctrl.flush;
  assign push     = ctrl.push_req && can_push;
  assign pop      = ctrl.pop_req && !empty;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    active_d = 1'b1;
    if (ctrl.flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + PW'(1);
        2'b01:   level_d = level_q - PW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      active_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      active_q <= active_d;
    end
  end

  assign ctrl.push      = push;
  assign ctrl.can_push  = can_push;
  assign ctrl.can_pop   = !empty;
  assign ctrl.wr_addr   = wr_ptr_q[AW-1:0];
  assign ctrl.rd_addr   = rd_ptr_q[AW-1:0];
  assign ctrl.level     = level_q;
  assign ctrl.level_nxt = level_d;

  a_level_matches_ptrs: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    level_q == (wr_ptr_q - rd_ptr_q));
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push && full));
  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(pop && empty));

endmodule

// File: rtl/qeciphy_tx_buffer.sv
// 64-bit AXI-Stream FIFO ahead of the TX channel encoder: absorbs FAW/CRC and
// link-down stalls, reports occupancy/high-water, and supports a sync flush.
module qeciphy_tx_buffer
  import qeciphy_pkg::*;
#(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 14
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [QECIPHY_DATA_W-1:0] s_axis_tdata_i,
  input  logic                      s_axis_tvalid_i,
  output logic                      s_axis_tready_o,
  output logic [QECIPHY_DATA_W-1:0] m_axis_tdata_o,
  output logic                      m_axis_tvalid_o,
  input  logic                      m_axis_tready_i,
  input  logic                      flush_i,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      almost_full_o,
  output logic [$clog2(DEPTH):0]    high_water_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (!qeciphy_is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("qeciphy_tx_buffer: DEPTH must be a power of two and at least 4");
  end
  if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > DEPTH) begin : g_bad_af
    $error("qeciphy_tx_buffer: ALMOST_FULL_LVL must lie in 1..DEPTH");
  end

  qeciphy_axis_if #(.DATA_W(QECIPHY_DATA_W)) s_axis ();
  qeciphy_axis_if #(.DATA_W(QECIPHY_DATA_W)) m_axis ();
  qeciphy_fifo_ctrl_if #(.DEPTH(DEPTH))      fifo_if ();

  assign s_axis.tdata    = s_axis_tdata_i;
  assign s_axis.tvalid   = s_axis_tvalid_i;
  assign s_axis_tready_o = s_axis.tready;
  assign m_axis.tready   = m_axis_tready_i;
  assign m_axis_tdata_o  = m_axis.tdata;
  assign m_axis_tvalid_o = m_axis.tvalid;

  assign fifo_if.push_req = s_axis.tvalid;
  assign fifo_if.pop_req  = m_axis.tready;
  assign fifo_if.flush    = flush_i;
  assign s_axis.tready    = fifo_if.can_push;
  assign m_axis.tvalid    = fifo_if.can_pop;

  qeciphy_sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .ctrl    (fifo_if.slave)
  );

  logic [QECIPHY_DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (fifo_if.push) mem_q[fifo_if.wr_addr] <= s_axis.tdata;
  end

  // First-word-fall-through: the head entry is always on the output.
  assign m_axis.tdata = mem_q[fifo_if.rd_addr];

  logic          almost_full_q, almost_full_d;
  logic [LW-1:0] high_water_q, high_water_d;

  // Both monitors look at next-state level so they line up with level_o.
  always_comb begin
    almost_full_d = (fifo_if.level_nxt >= LW'(ALMOST_FULL_LVL));
    high_water_d  = high_water_q;
    if (flush_i) begin
      high_water_d = '0;
    end else if (fifo_if.level_nxt > high_water_q) begin
      high_water_d = fifo_if.level_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      almost_full_q <= 1'b0;
      high_water_q  <= '0;
    end else begin
      almost_full_q <= almost_full_d;
      high_water_q  <= high_water_d;
    end
  end

  assign level_o       = fifo_if.level;
  assign almost_full_o = almost_full_q;
  assign high_water_o  = high_water_q;

endmodule
